// File: rtl/seq_controller_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the opcode values, the eight phase encodings, the run/halted state
// encoding, the packed strobe bundle produced by the decoder, and the
// ALU-class membership test.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HALTED  = 1'b1
  } state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
    logic halt;
  } strobes_t;

  // Instructions that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Bus bundle between the sequencer and the datapath.
//   en, opcode, zero      : run enable, IR opcode field, accumulator-zero flag
//   sel .. halt           : datapath control strobes
//   phase, instr_cnt      : debug phase and retired-instruction count
// slave  = sequencer side, master = datapath/stimulus side.
interface seq_controller_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [2:0]       opcode;
  logic             zero;
  logic             sel;
  logic             rd;
  logic             ld_ir;
  logic             inc_pc;
  logic             ld_pc;
  logic             ld_ac;
  logic             wr;
  logic             data_e;
  logic             halt;
  logic [2:0]       phase;
  logic [CNT_W-1:0] instr_cnt;

  modport slave (
    input  en, opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, instr_cnt
  );

  modport master (
    output en, opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, instr_cnt
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational strobe table of the sequencer.
// Inputs : phase, opcode, zero, halted, en
// Output : strobes (packed bundle of sel/rd/ld_ir/inc_pc/ld_pc/ld_ac/wr/data_e/halt)
module seq_decode
  import cpu_pkg::*;
(
  input  logic [2:0] phase,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       halted,
  input  logic       en,
  output strobes_t   strobes
);

  logic aluop;
  assign aluop = is_aluop(opcode);

  always_comb begin
    strobes = '0;
    if (halted) begin
      strobes.halt = 1'b1;
    end else begin
      case (phase)
        PH_INST_ADDR: begin
          strobes.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          strobes.sel = 1'b1;
          strobes.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          strobes.sel   = 1'b1;
          strobes.rd    = 1'b1;
          strobes.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          strobes.inc_pc = (opcode != OP_HLT);
          strobes.halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: begin
          strobes.rd = aluop;
        end
        PH_ALU_OP: begin
          strobes.rd     = aluop;
          strobes.inc_pc = (opcode == OP_SKZ) && zero;
          strobes.ld_pc  = (opcode == OP_JMP);
          strobes.data_e = (opcode == OP_STO);
        end
        default: begin  // PH_STORE
          strobes.rd     = aluop;
          strobes.ld_ac  = aluop;
          strobes.ld_pc  = (opcode == OP_JMP);
          strobes.wr     = (opcode == OP_STO);
          strobes.data_e = (opcode == OP_STO);
        end
      endcase
      // A stall suppresses every state-changing strobe; address, read and
      // bus-drive levels stay put so the memory interface stays stable.
      if (!en) begin
        strobes.ld_ir  = 1'b0;
        strobes.inc_pc = 1'b0;
        strobes.ld_pc  = 1'b0;
        strobes.ld_ac  = 1'b0;
        strobes.wr     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Eight-phase instruction sequencer.
// Ports: clk, rst (synchronous, active-high), bus (slave modport carrying
// en/opcode/zero in and all strobes, phase and instr_cnt out).
// CNT_W must match the CNT_W of the connected interface instance.
module seq_controller
  import cpu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_controller_if.slave  bus
);

  state_t           state_reg, state_next;
  logic [2:0]       phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  strobes_t         strobes;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      phase_reg <= PH_INST_ADDR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: HALTED is absorbing, RUN advances only while enabled.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_RUN && bus.en) begin
      if (phase_reg == PH_OP_ADDR && bus.opcode == OP_HLT) begin
        // phase parks at OP_ADDR so the debug port shows where it stopped
        state_next = ST_HALTED;
      end else begin
        phase_next = phase_reg + 3'd1;
      end
      if (phase_reg == PH_STORE) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Output logic
  seq_decode u_decode (
    .phase   (phase_reg),
    .opcode  (bus.opcode),
    .zero    (bus.zero),
    .halted  (state_reg == ST_HALTED),
    .en      (bus.en),
    .strobes (strobes)
  );

  assign bus.sel       = strobes.sel;
  assign bus.rd        = strobes.rd;
  assign bus.ld_ir     = strobes.ld_ir;
  assign bus.inc_pc    = strobes.inc_pc;
  assign bus.ld_pc     = strobes.ld_pc;
  assign bus.ld_ac     = strobes.ld_ac;
  assign bus.wr        = strobes.wr;
  assign bus.data_e    = strobes.data_e;
  assign bus.halt      = strobes.halt;
  assign bus.phase     = phase_reg;
  assign bus.instr_cnt = cnt_reg;

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter: CNT_W, default 8, width of retired-instruction counter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  run enable; 0 freezes sequencing.
REQ-005 opcode  input  3  instruction-register opcode field.
REQ-006 zero  input  1  accumulator-is-zero flag.
REQ-007 sel  output  1  memory address mux: 1=PC, 0=IR operand.
REQ-008 rd  output  1  memory read enable.
REQ-009 ld_ir  output  1  load instruction register.
REQ-010 inc_pc  output  1  increment PC.
REQ-011 ld_pc  output  1  load PC from operand.
REQ-012 ld_ac  output  1  load accumulator.
REQ-013 wr  output  1  memory write strobe.
REQ-014 data_e  output  1  drive AC onto memory data bus.
REQ-015 halt  output  1  CPU halted.
REQ-016 phase  output  3  current phase, debug.
REQ-017 instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-018 Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP = ADD|AND|XOR|LDA.
REQ-019 States RUN and HALTED; in RUN a 3-bit phase advances by 1 per clock when en=1, wrapping 7->0.
REQ-020 Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-021 Strobes are combinational decode of registered phase and opcode; one-instruction latency = 8 enabled cycles.
REQ-022 Phase 0: sel. Phase 1: sel, rd. Phases 2-3: sel, rd, ld_ir.
REQ-023 Phase 4: inc_pc if opcode!=HLT; halt if opcode==HLT.
REQ-024 Phase 5: rd if ALUOP.
REQ-025 Phase 6: rd if ALUOP; inc_pc if SKZ and zero=1; ld_pc if JMP; data_e if STO.
REQ-026 Phase 7: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
REQ-027 RUN->HALTED on the edge ending phase 4 with opcode==HLT and en=1; phase holds at 4.
REQ-028 HALTED: halt=1, all other strobes 0, en ignored; exit only by rst.
REQ-029 en=0 in RUN: phase holds; ld_ir, inc_pc, ld_pc, ld_ac, wr forced 0; sel, rd, data_e keep decoded levels.
REQ-030 instr_cnt increments on each edge ending phase 7 with en=1; wraps modulo 2^CNT_W; HLT not counted.
REQ-031 SKZ with zero=0 and all undefined combinations: no inc_pc in phase 6.

Reset
REQ-032 rst=1 at an edge: state=RUN, phase=0, instr_cnt=0, regardless of en or current phase, including mid-instruction and HALTED.
REQ-033 After reset edge outputs: sel=1, all other strobes 0, halt=0, phase=0.
REQ-034 rst has priority over en and the HALT transition in the same cycle.

Structure
REQ-035 Package cpu_pkg holds opcode constants, phase encodings and the ALUOP membership function.
REQ-036 One sub-module seq_decode: purely combinational phase/opcode/zero/state/en -> strobe table; seq_controller holds state, phase and counter registers.

Verification
REQ-037 LDA (opcode=5), en=1 from reset -> phases 0..7 in 8 cycles; ld_ir high in phases 2-3, inc_pc in 4, ld_ac in 7; instr_cnt=1.
REQ-038 SKZ, zero=1 -> inc_pc high in phases 4 and 6; repeat with zero=0 -> inc_pc only in phase 4.
REQ-039 STO (opcode=6) -> data_e in phases 6-7, wr only in 7; JMP (opcode=7) -> ld_pc in 6-7, rd never after phase 3.
REQ-040 HLT (opcode=0) -> halt=1, inc_pc=0 in phase 4; next cycle HALTED, phase stays 4, halt stays 1 for 20 cycles with en toggling; instr_cnt unchanged.
REQ-041 ADD with en=0 for 3 cycles at phase 7 -> phase holds 7, ld_ac=0 during stall, ld_ac=1 for exactly one cycle after en=1; instr_cnt advances once.
REQ-042 rst asserted in phase 5 and in HALTED -> next cycle phase=0, sel=1, halt=0, instr_cnt=0; 256 ADDs wrap instr_cnt 255->0.
